// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam logic [3:0]  MID_SAMPLE = 4'd7;

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head entry is visible on rdata.
module uart_rx_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fill    = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8-bit UART receiver, 16x oversampling, optional parity, FWFT receive FIFO.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DIV_WIDTH-1:0]        cfg_div_i,
  input  logic                        cfg_parity_en_i,
  input  logic                        cfg_parity_odd_i,
  input  logic                        rx_en_i,
  input  logic                        rx_i,
  output logic [7:0]                  data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [$clog2(FIFO_DEPTH):0] fill_o,
  output logic                        frame_err_o,
  output logic                        parity_err_o,
  output logic                        overflow_o
);

  localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);

  uart_rx_state_e       state;
  uart_rx_state_e       next_state;
  logic                 rx_meta;
  logic                 rx_s;
  logic [DIV_WIDTH-1:0] tick_cnt;
  logic                 tick;
  logic [3:0]           sample_cnt;
  logic                 mid;
  logic [7:0]           shift;
  logic [2:0]           bit_cnt;
  logic                 par_bad;
  logic                 shift_en;
  logic                 par_chk;
  logic                 push;
  logic                 frame_err;
  logic                 parity_err;
  logic                 fifo_full;
  logic                 fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  assign tick = (tick_cnt == cfg_div_i);
  assign mid  = tick && (sample_cnt == MID_SAMPLE);

  // Both counters are held at zero in IDLE, which also clears them on entry to START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt   <= '0;
      sample_cnt <= '0;
    end else if (state == IDLE) begin
      tick_cnt   <= '0;
      sample_cnt <= '0;
    end else if (tick) begin
      tick_cnt   <= '0;
      sample_cnt <= (sample_cnt == LAST_SAMPLE) ? '0 : sample_cnt + 4'd1;
    end else begin
      tick_cnt   <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    shift_en   = 1'b0;
    par_chk    = 1'b0;
    push       = 1'b0;
    frame_err  = 1'b0;
    parity_err = 1'b0;
    case (state)
      IDLE:   if (!rx_s) next_state = START;
      START:  if (mid) next_state = rx_s ? IDLE : DATA;
      DATA: begin
        if (mid) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) next_state = cfg_parity_en_i ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (mid) begin
          par_chk    = 1'b1;
          next_state = STOP;
        end
      end
      STOP: begin
        if (mid) begin
          if (rx_s) begin
            next_state = IDLE;
            if (par_bad) parity_err = 1'b1;
            else         push       = 1'b1;
          end else begin
            frame_err  = 1'b1;
            next_state = BREAK;
          end
        end
      end
      BREAK:  if (rx_s) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (!rx_en_i) begin
      next_state = IDLE;
      shift_en   = 1'b0;
      par_chk    = 1'b0;
      push       = 1'b0;
      frame_err  = 1'b0;
      parity_err = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift   <= '0;
      bit_cnt <= '0;
      par_bad <= 1'b0;
    end else if (state == IDLE) begin
      bit_cnt <= '0;
      par_bad <= 1'b0;
    end else begin
      if (shift_en) begin
        shift   <= {rx_s, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (par_chk) par_bad <= (rx_s != (^shift ^ cfg_parity_odd_i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      frame_err_o  <= frame_err;
      parity_err_o <= parity_err;
      overflow_o   <= push && fifo_full && !ready_i;
    end
  end

  assign valid_o = !fifo_empty;

  uart_rx_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (shift),
    .pop   (ready_i),
    .rdata (data_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (fill_o)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: 8N1/parity frames, glitch, framing, overflow, reset and enable.
module tb_uart_rx_fifo;
  import uart_rx_pkg::*;

  localparam int BIT = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cfg_div = 16'd3;
  logic        par_en = 1'b0;
  logic        par_odd = 1'b0;
  logic        rx_en = 1'b1;
  logic        rx = 1'b1;
  logic        ready = 1'b0;
  logic [7:0]  data;
  logic        valid;
  logic [3:0]  fill;
  logic        ferr;
  logic        perr;
  logic        ovf;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_ferr = 0;
  int n_perr = 0;
  int n_ovf = 0;
  int valid_cyc = -1;
  int t0 = 0;
  int f0, p0, o0;
  logic arm = 1'b0;

  uart_rx_fifo #(
    .FIFO_DEPTH (8),
    .DIV_WIDTH  (16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_div_i        (cfg_div),
    .cfg_parity_en_i  (par_en),
    .cfg_parity_odd_i (par_odd),
    .rx_en_i          (rx_en),
    .rx_i             (rx),
    .data_o           (data),
    .valid_o          (valid),
    .ready_i          (ready),
    .fill_o           (fill),
    .frame_err_o      (ferr),
    .parity_err_o     (perr),
    .overflow_o       (ovf)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ferr) n_ferr++;
    if (perr) n_perr++;
    if (ovf)  n_ovf++;
    if (arm && valid && valid_cyc < 0) valid_cyc = cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bitw(input logic v);
    rx = v;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic pe, input logic pb, input logic sb);
    bitw(1'b0);
    for (int i = 0; i < 8; i++) bitw(b[i]);
    if (pe) bitw(pb);
    bitw(sb);
  endtask

  task automatic partial(input logic [7:0] b);
    bitw(1'b0);
    for (int i = 0; i < 3; i++) bitw(b[i]);
    rx = b[3];
    repeat (BIT / 2) @(posedge clk);
    #1;
  endtask

  task automatic rest(input logic [7:0] b);
    repeat (BIT / 2) @(posedge clk);
    #1;
    for (int i = 4; i < 8; i++) bitw(b[i]);
    bitw(1'b1);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop1();
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_fill", 32'(fill), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_flags", {29'd0, ferr, perr, ovf}, 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    rst_n = 1'b1;
    idle(5);

    // basic 8N1 byte and latency from rx fall to valid
    arm = 1'b1;
    valid_cyc = -1;
    t0 = cyc;
    send(8'hA5, 1'b0, 1'b0, 1'b1);
    chk("a5_latency_ok", 32'((valid_cyc - t0) >= 609 && (valid_cyc - t0) <= 613), 32'd1);
    chk("a5_valid", 32'(valid), 32'd1);
    chk("a5_data", 32'(data), 32'hA5);
    chk("a5_fill", 32'(fill), 32'd1);
    arm = 1'b0;
    pop1();
    chk("a5_pop_fill", 32'(fill), 32'd0);
    chk("a5_pop_valid", 32'(valid), 32'd0);

    // glitch rejection
    f0 = n_ferr; p0 = n_perr;
    rx = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    chk("glitch_in_start", 32'(dut.state), 32'(START));
    rx = 1'b1;
    repeat (24) @(posedge clk);
    #1;
    chk("glitch_idle_by_40", 32'(dut.state), 32'(IDLE));
    idle(100);
    chk("glitch_fill", 32'(fill), 32'd0);
    chk("glitch_ferr", 32'(n_ferr), 32'(f0));
    chk("glitch_perr", 32'(n_perr), 32'(p0));

    // framing error, held-low line, then recovery
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    chk("ferr_pulse", 32'(n_ferr), 32'(f0 + 1));
    chk("ferr_fill", 32'(fill), 32'd0);
    chk("ferr_break", 32'(dut.state), 32'(BREAK));
    idle(20);
    chk("ferr_back_idle", 32'(dut.state), 32'(IDLE));
    send(8'h3C, 1'b0, 1'b0, 1'b1);
    chk("ferr_next_data", 32'(data), 32'h3C);
    chk("ferr_next_fill", 32'(fill), 32'd1);
    chk("ferr_no_more", 32'(n_ferr), 32'(f0 + 1));
    pop1();

    // odd parity
    par_en = 1'b1;
    par_odd = 1'b1;
    send(8'h01, 1'b1, 1'b0, 1'b1);
    chk("par_ok_fill", 32'(fill), 32'd1);
    chk("par_ok_data", 32'(data), 32'h01);
    chk("par_ok_noerr", 32'(n_perr), 32'(p0));
    pop1();
    send(8'h01, 1'b1, 1'b1, 1'b1);
    chk("par_bad_pulse", 32'(n_perr), 32'(p0 + 1));
    chk("par_bad_fill", 32'(fill), 32'd0);
    chk("par_bad_noferr", 32'(n_ferr), 32'(f0 + 1));
    par_en = 1'b0;
    par_odd = 1'b0;
    idle(10);

    // overflow and in-order drain
    o0 = n_ovf;
    for (int i = 0; i < 9; i++) send(8'(i), 1'b0, 1'b0, 1'b1);
    chk("ovf_fill", 32'(fill), 32'd8);
    chk("ovf_pulse", 32'(n_ovf), 32'(o0 + 1));
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 32'(valid), 32'd1);
      chk("drain_data", 32'(data), 32'(i));
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 32'(valid), 32'd0);
    ready = 1'b0;
    chk("drain_fill", 32'(fill), 32'd0);

    // asynchronous reset in DATA bit 3
    send(8'h11, 1'b0, 1'b0, 1'b1);
    chk("rst_pre_fill", 32'(fill), 32'd1);
    partial(8'h5A);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(valid), 32'd0);
    chk("rst_mid_fill", 32'(fill), 32'd0);
    chk("rst_mid_state", 32'(dut.state), 32'(IDLE));
    rest(8'h5A);
    rst_n = 1'b1;
    idle(10);
    send(8'h5A, 1'b0, 1'b0, 1'b1);
    chk("rst_next_data", 32'(data), 32'h5A);
    chk("rst_next_fill", 32'(fill), 32'd1);
    pop1();

    // enable dropped in DATA bit 3
    send(8'h22, 1'b0, 1'b0, 1'b1);
    partial(8'h5A);
    rx_en = 1'b0;
    @(posedge clk);
    #1;
    chk("en_forced_idle", 32'(dut.state), 32'(IDLE));
    rest(8'h5A);
    idle(10);
    rx_en = 1'b1;
    idle(10);
    chk("en_fill_kept", 32'(fill), 32'd1);
    chk("en_data_kept", 32'(data), 32'h22);
    send(8'h5A, 1'b0, 1'b0, 1'b1);
    chk("en_next_fill", 32'(fill), 32'd2);
    chk("en_head", 32'(data), 32'h22);
    pop1();
    chk("en_second", 32'(data), 32'h5A);
    pop1();
    chk("en_empty", 32'(valid), 32'd0);

    chk("total_ovf", 32'(n_ovf), 32'(o0 + 1));
    chk("total_ferr", 32'(n_ferr), 32'(f0 + 1));
    chk("total_perr", 32'(n_perr), 32'(p0 + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
